ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
- System-clock PS/2 receiver that replaces direct clocking on PS2Clk.
- Synchronises and deglitches PS2Clk/PS2Data, then decodes 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
- Checks parity, stop bit and inter-bit timeout; buffers good bytes in a show-ahead FIFO for the downstream blur-control logic.

Parameters:
FILTER_LEN, 8, consecutive clk cycles PS2Clk must hold a new level before the filtered clock follows (>=2)
TIMEOUT_CYC, 200000, clk cycles without a filtered falling edge before a partial frame is aborted (2 ms at 100 MHz)
FIFO_DEPTH, 16, bytes of buffering; power of two, >=2
CNT_W, 8, width of o_frameCnt

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
PS2Clk  input  1  raw PS/2 clock, asynchronous
PS2Data  input  1  raw PS/2 data, asynchronous
i_rd  input  1  pop request; acts only when o_empty=0
o_data  output  8  FIFO head byte; valid while o_empty=0
o_empty  output  1  FIFO empty
o_full  output  1  FIFO full
o_fill  output  log2(FIFO_DEPTH)+1  bytes held
o_parity_err  output  1  1-cycle pulse: frame dropped for bad parity
o_frame_err  output  1  1-cycle pulse: bad start/stop bit or timeout
o_overflow  output  1  sticky: a good byte was dropped because the FIFO was full
o_frameCnt  output  CNT_W  count of bytes pushed; wraps

Behaviour:
- Reset (rst_n=0, async):
  - FSM to IDLE; synchronisers and filtered clock to 1; timeout counter 0; FIFO pointers 0.
  - Outputs: o_empty=1; o_full, o_fill, o_data, both error pulses, o_overflow, o_frameCnt all 0.
  - Reset mid-frame discards the partial frame silently (no error pulse).
- Input path:
  - 2-FF synchroniser on each input.
  - Filter: a counter runs while synced PS2Clk differs from the filtered level. The filtered level flips when the count reaches FILTER_LEN, and the counter clears whenever the levels match.
  - Sample event: a 1-cycle pulse when the filtered level goes 1->0. Synced PS2Data is captured in the same cycle.
- FSM (advances only on sample events, except for timeout):
  - IDLE: data=0 -> DATA, bit index 0. Data=1 -> o_frame_err pulse, stay IDLE.
  - DATA: shift the bit into shift[index], LSB first. After index 7 -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: stop=1 and XOR(data,parity)=1 -> push. Stop=0 -> o_frame_err. Stop=1 with even parity -> o_parity_err. Stop=0 takes priority over a parity fault. Always return to IDLE.
- Timeout:
  - The counter clears on every sample event and in IDLE; otherwise it increments.
  - At TIMEOUT_CYC (non-IDLE): go to IDLE, pulse o_frame_err. The counter saturates, never wraps.
- Push latency: the push is registered the cycle after the stop-bit sample event. o_empty falls and o_data is valid 2 clk cycles after that event. o_frameCnt increments on the same cycle as the push.
- FIFO (show-ahead):
  - i_rd with o_empty=1 is ignored.
  - Push while full, with no pop that cycle: byte dropped, o_overflow=1 until reset, o_frameCnt not incremented.
  - Push and pop in the same cycle (any fill, including full): both happen, o_fill unchanged.
  - o_full = (o_fill==FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH.
- Error pulses are exactly 1 clk wide and never assert together.

Test Plan:
- Valid frame: 0x1C (start 0, data 00111000 LSB first, parity 0, stop 1), ~80 us bit period -> o_empty falls 2 cycles after the stop sample; o_data=0x1C; o_fill=1; o_frameCnt=1; no error pulses. Then i_rd for 1 cycle -> o_empty=1.
- Bad parity: 0x1C with parity 1 -> one o_parity_err pulse; o_empty stays 1; o_frameCnt=0. Bad stop on 0xF0 -> one o_frame_err pulse only.
- Glitch: PS2Clk low for FILTER_LEN-1 cycles while IDLE and data=0 -> no state change. A low of FILTER_LEN+2 cycles -> FSM enters DATA.
- Timeout: send start plus 4 data bits, then hold PS2Clk high -> o_frame_err exactly TIMEOUT_CYC cycles after the last sample. A following 0xF0 frame is received correctly.
- Overflow: 17 valid frames (0x01..0x11), no reads -> o_full=1, o_overflow=1, o_frameCnt=16. Reads return 0x01..0x10 in order, then o_empty=1. Repeat with full FIFO plus push and i_rd in the same cycle -> o_fill stays 16, no overflow.
- Reset mid-frame: assert rst_n=0 after 5 data bits -> all outputs at reset values, no error pulse. The next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver running on the system clock: input sync and deglitch,
// 11-bit frame decode with parity/stop/timeout checks, show-ahead byte FIFO.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         PS2Clk,
  input  logic                         PS2Data,
  input  logic                         i_rd,
  output logic [7:0]                   o_data,
  output logic                         o_empty,
  output logic                         o_full,
  output logic [$clog2(FIFO_DEPTH):0]  o_fill,
  output logic                         o_parity_err,
  output logic                         o_frame_err,
  output logic                         o_overflow,
  output logic [CNT_W-1:0]             o_frameCnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FC_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic r_clk_s1, r_clk_s2;
  logic r_dat_s1, r_dat_s2;
  logic r_filt;
  logic [FW-1:0] r_fcnt;
  logic r_sample;
  logic r_bit;
  logic w_fall;

  logic [TW-1:0] r_to;
  logic w_to_hit;

  state_t r_state, w_state_n;
  logic [2:0] r_idx, w_idx_n;
  logic [7:0] r_shift, w_shift_n;
  logic r_par, w_par_n;
  logic r_push, w_push_n;
  logic r_perr, w_perr_n;
  logic r_ferr, w_ferr_n;

  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_fill;
  logic r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic w_empty, w_full, w_do_pop, w_do_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= PS2Clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= PS2Data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_filt & ~r_clk_s2 & (r_fcnt == FC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt   <= 1'b1;
      r_fcnt   <= '0;
      r_sample <= 1'b0;
      r_bit    <= 1'b1;
    end else begin
      r_sample <= w_fall;
      if (w_fall) r_bit <= r_dat_s2;
      if (r_clk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FC_LAST) begin
        r_filt <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  // the count reaches TIMEOUT_CYC on the edge where w_to_hit is seen
  assign w_to_hit = (r_state != S_IDLE) && (r_to == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to <= '0;
    end else if (r_state == S_IDLE || w_fall) begin
      r_to <= '0;
    end else if (r_to != TO_MAX) begin
      r_to <= r_to + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_push  <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_push  <= w_push_n;
      r_perr  <= w_perr_n;
      r_ferr  <= w_ferr_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_push_n  = 1'b0;
    w_perr_n  = 1'b0;
    w_ferr_n  = 1'b0;
    if (w_to_hit) begin
      w_state_n = S_IDLE;
      w_ferr_n  = 1'b1;
    end else if (r_sample) begin
      unique case (r_state)
        S_IDLE: begin
          if (r_bit) begin
            w_ferr_n = 1'b1;
          end else begin
            w_state_n = S_DATA;
            w_idx_n   = '0;
          end
        end
        S_DATA: begin
          w_shift_n[r_idx] = r_bit;
          if (r_idx == 3'd7) w_state_n = S_PAR;
          else w_idx_n = r_idx + 3'd1;
        end
        S_PAR: begin
          w_par_n   = r_bit;
          w_state_n = S_STOP;
        end
        S_STOP: begin
          w_state_n = S_IDLE;
          if (!r_bit) w_ferr_n = 1'b1;
          else if (^{r_shift, r_par}) w_push_n = 1'b1;
          else w_perr_n = 1'b1;
        end
      endcase
    end
  end

  assign w_empty   = (r_fill == '0);
  assign w_full    = (r_fill == DEPTH);
  assign w_do_pop  = i_rd & ~w_empty;
  // a full FIFO still accepts a byte when a pop frees the slot this cycle
  assign w_do_push = r_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      if (r_push & w_full & ~w_do_pop) r_ovf <= 1'b1;
    end
  end

  assign o_data       = w_empty ? 8'h00 : r_mem[r_rptr];
  assign o_empty      = w_empty;
  assign o_full       = w_full;
  assign o_fill       = r_fill;
  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;
  assign o_overflow   = r_ovf;
  assign o_frameCnt   = r_cnt;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomized bench for ps2_rx_fifo against a queue-based frame/FIFO model.
// Raw PS/2 edges are driven on the falling system clock edge.
module tb_ps2_rx_fifo;

  localparam int FL    = 8;
  localparam int TO    = 400;
  localparam int DEPTH = 16;
  localparam int CW    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic PS2Clk = 1'b1;
  logic PS2Data = 1'b1;
  logic i_rd = 1'b0;
  logic [7:0] o_data;
  logic o_empty, o_full;
  logic [4:0] o_fill;
  logic o_parity_err, o_frame_err, o_overflow;
  logic [CW-1:0] o_frameCnt;

  ps2_rx_fifo #(
    .FILTER_LEN(FL),
    .TIMEOUT_CYC(TO),
    .FIFO_DEPTH(DEPTH),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .PS2Clk(PS2Clk),
    .PS2Data(PS2Data),
    .i_rd(i_rd),
    .o_data(o_data),
    .o_empty(o_empty),
    .o_full(o_full),
    .o_fill(o_fill),
    .o_parity_err(o_parity_err),
    .o_frame_err(o_frame_err),
    .o_overflow(o_overflow),
    .o_frameCnt(o_frameCnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  int n_pe = 0, n_fe = 0;
  int pe_cyc = 0, fe_cyc = 0, fall_cyc = 0;
  logic pe_q = 1'b0, fe_q = 1'b0, emp_q = 1'b1;

  always @(negedge clk) begin
    if (o_parity_err || o_frame_err)
      chk("err_excl", o_parity_err & o_frame_err, 0);
    if (o_parity_err) begin
      n_pe++;
      pe_cyc = cyc;
      chk("pe_width", pe_q, 0);
    end
    if (o_frame_err) begin
      n_fe++;
      fe_cyc = cyc;
      chk("fe_width", fe_q, 0);
    end
    if (emp_q && !o_empty) fall_cyc = cyc;
    pe_q  = o_parity_err;
    fe_q  = o_frame_err;
    emp_q = o_empty;
  end

  logic [7:0] q[$];
  bit m_ovf = 1'b0;
  int m_cnt = 0, e_pe = 0, e_fe = 0;
  int c_last = 0;

  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bp, input bit bs,
                            input int nbits, input int lo0, input bit pp);
    logic [10:0] b;
    int h;
    b = {~bs, (~^d) ^ bp, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      h = $urandom_range(20, 30);
      PS2Data = b[i];
      wait_cyc(h / 2);
      PS2Clk = 1'b0;
      c_last = cyc;
      if (pp && i == 10) begin
        wait_cyc(FL + 3);
        i_rd = 1'b1;
        wait_cyc(1);
        i_rd = 1'b0;
        wait_cyc(h - FL - 4);
      end else begin
        wait_cyc((i == 0 && lo0 != 0) ? lo0 : h);
      end
      PS2Clk = 1'b1;
      wait_cyc(h / 2);
    end
    PS2Data = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit bp, input bit bs,
                             input bit pp);
    if (bs) e_fe++;
    else if (bp) e_pe++;
    else if (q.size() == DEPTH && !pp) m_ovf = 1'b1;
    else begin
      if (pp && q.size() != 0) void'(q.pop_front());
      q.push_back(d);
      m_cnt++;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_fill"}, o_fill, q.size());
    chk({tag, "_empty"}, o_empty, q.size() == 0);
    chk({tag, "_full"}, o_full, q.size() == DEPTH);
    chk({tag, "_ovf"}, o_overflow, m_ovf);
    chk({tag, "_cnt"}, o_frameCnt, m_cnt % (1 << CW));
    chk({tag, "_data"}, o_data, q.size() != 0 ? q[0] : 8'h00);
    chk({tag, "_perr"}, n_pe, e_pe);
    chk({tag, "_ferr"}, n_fe, e_fe);
  endtask

  // sample event lands 2 sync + FILTER_LEN cycles after the raw fall;
  // a push shows 2 cycles later, an error pulse 1 cycle later
  task automatic do_frame(input logic [7:0] d, input bit bp, input bit bs,
                          input int lo0, input bit pp);
    bit was_empty;
    was_empty = (q.size() == 0);
    send_frame(d, bp, bs, 11, lo0, pp);
    wait_cyc(20);
    if (bs) chk("fe_lat", fe_cyc - c_last, FL + 3);
    else if (bp) chk("pe_lat", pe_cyc - c_last, FL + 3);
    else if (was_empty) chk("push_lat", fall_cyc - c_last, FL + 4);
    model_frame(d, bp, bs, pp);
    check_state("frm");
  endtask

  task automatic do_read();
    if (q.size() != 0) chk("rd_head", o_data, q[0]);
    i_rd = 1'b1;
    @(negedge clk);
    i_rd = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    chk("rd_fill", o_fill, q.size());
    chk("rd_empty", o_empty, q.size() == 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    q.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
    check_state("rst");
    chk("rst_pe", o_parity_err, 0);
    chk("rst_fe", o_frame_err, 0);
    rst_n = 1'b1;
    wait_cyc(5);
  endtask

  initial begin
    int fe0;
    int r;
    logic [7:0] d;
    @(negedge clk);
    do_reset();

    do_frame(8'h1C, 1'b0, 1'b0, 0, 1'b0);
    do_read();
    do_frame(8'h1C, 1'b1, 1'b0, 0, 1'b0);
    do_frame(8'hF0, 1'b0, 1'b1, 0, 1'b0);

    PS2Data = 1'b0;
    wait_cyc(10);
    PS2Clk = 1'b0;
    wait_cyc(FL - 1);
    PS2Clk = 1'b1;
    wait_cyc(30);
    PS2Data = 1'b1;
    wait_cyc(10);
    check_state("glitch");
    do_frame(8'h3A, 1'b0, 1'b0, FL + 2, 1'b0);

    fe0 = n_fe;
    send_frame(8'hA5, 1'b0, 1'b0, 5, 0, 1'b0);
    for (int k = 0; k < TO + 100 && n_fe == fe0; k++) @(negedge clk);
    wait_cyc(2);
    chk("to_seen", n_fe - fe0, 1);
    chk("to_lat", fe_cyc - c_last, FL + 2 + TO);
    e_fe++;
    check_state("to");
    do_frame(8'hF0, 1'b0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      d = 8'($urandom);
      r = $urandom_range(0, 7);
      do_frame(d, (r == 0 || r == 2), (r == 1 || r == 2), 0, 1'b0);
      repeat ($urandom_range(0, 2)) do_read();
    end

    do_reset();
    for (int i = 1; i <= 17; i++) do_frame(8'(i), 1'b0, 1'b0, 0, 1'b0);
    check_state("ovf");
    repeat (16) do_read();
    chk("ovf_drained", o_empty, 1);

    do_reset();
    for (int i = 0; i < 16; i++) do_frame(8'h20 + 8'(i), 1'b0, 1'b0, 0, 1'b0);
    do_frame(8'h77, 1'b0, 1'b0, 0, 1'b1);
    chk("pp_fill", o_fill, 16);
    chk("pp_ovf", o_overflow, 0);
    repeat (16) do_read();

    do_frame(8'h11, 1'b0, 1'b0, 0, 1'b0);
    do_frame(8'h22, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 6, 0, 1'b0);
    do_reset();
    wait_cyc(20);
    check_state("midrst");
    do_frame(8'h5A, 1'b0, 1'b0, 0, 1'b0);
    do_read();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
